ct_ifu_spsram_512x22_ctrl: RTL and testbench
============================================

Name: ct_ifu_spsram_512x22_ctrl

Overview:
Access controller sitting directly upstream of the IFU 512x22 single-port SRAM wrapper; drives its A/CEN/GWEN/WEN/D pins and consumes Q.
- Arbitrates one read port and one bit-masked write port onto the single SRAM port.
- Runs a hardware invalidate sweep that zeroes all 512 entries, on request and optionally after reset.
- Returns read data with a fixed one-cycle latency and a valid strobe.

Parameters:
- ADDR_WIDTH, 9, SRAM index width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 22, entry width; also the WEN width.
- INV_ON_RESET, 1, 1 = start an invalidate sweep automatically after reset release.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  asynchronous active-low reset.
- inv_req  in  1  single-cycle invalidate-all request.
- inv_busy  out  1  sweep in progress.
- inv_done  out  1  one-cycle pulse after the last entry is written.
- wr_req  in  1  write request.
- wr_idx  in  ADDR_WIDTH  write index.
- wr_data  in  DATA_WIDTH  write data.
- wr_mask  in  DATA_WIDTH  per-bit write enable, active-high.
- wr_gnt  out  1  write accepted this cycle.
- rd_req  in  1  read request.
- rd_idx  in  ADDR_WIDTH  read index.
- rd_gnt  out  1  read accepted this cycle.
- rd_vld  out  1  rd_data valid; asserted one cycle after rd_gnt.
- rd_data  out  DATA_WIDTH  read data.
- sram_a  out  ADDR_WIDTH  to SRAM A.
- sram_cen  out  1  to SRAM CEN, active-low.
- sram_gwen  out  1  to SRAM GWEN, active-low global write.
- sram_wen  out  DATA_WIDTH  to SRAM WEN, active-low per bit.
- sram_d  out  DATA_WIDTH  to SRAM D.
- sram_q  in  DATA_WIDTH  from SRAM Q.

Behaviour:
- Clocking/reset: single clock forever_cpuclk. cpurst_b is asynchronous, active-low.
- FSM: IDLE and INV. All flops are reset by cpurst_b.
- Reset values: state=IDLE, inv_cnt=0, inv_busy=0, inv_done=0, rd_vld=0. While cpurst_b is low: wr_gnt=0, rd_gnt=0, sram_cen=1, sram_gwen=1, sram_wen=all 1.
- IDLE->INV:
  - when inv_req=1; or
  - on the first clock edge after reset release when INV_ON_RESET=1.
- INV operation:
  - Each cycle drive sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a=inv_cnt.
  - inv_cnt increments by 1 each cycle. inv_busy=1.
- INV->IDLE: on the cycle inv_cnt==2^ADDR_WIDTH-1 (the last write). inv_cnt wraps to 0. inv_done pulses the following cycle. Sweep takes exactly 512 cycles.
- inv_req during INV is ignored; the sweep neither restarts nor extends.
- Grants in INV: wr_gnt=0 and rd_gnt=0. Requesters hold their requests; no request is dropped by the controller.
- Priority in IDLE: inv_req > wr_req > rd_req. Grants are combinational from req and state.
- Write grant (wr_gnt=1):
  - sram_cen=0, sram_gwen=0, sram_a=wr_idx, sram_d=wr_data, sram_wen=~wr_mask.
  - wr_mask=0 is still granted: SRAM enabled, no bit changes.
- Read grant (rd_gnt=1): sram_cen=0, sram_gwen=1, sram_a=rd_idx, sram_wen=all 1.
- Simultaneous wr_req and rd_req: write wins; the read waits at least one cycle.
- Simultaneous inv_req with wr_req/rd_req in IDLE: inv wins. Both grants are 0 that cycle, and the sweep starts next cycle with inv_cnt=0.
- Idle pins: no grant and not in INV -> sram_cen=1, sram_gwen=1, sram_wen=all 1. sram_a and sram_d are don't-care but driven to 0.
- Read return: rd_vld is a flop of rd_gnt, giving 1-cycle latency. rd_data=sram_q when rd_vld=1.
- Back-to-back reads: one per cycle, full throughput.
- Write-then-read of the same index on consecutive cycles returns the new data; the SRAM is write-first by ordering.
- Reset mid-sweep: state returns to IDLE and inv_cnt=0. With INV_ON_RESET=1 the sweep restarts from index 0. With INV_ON_RESET=0 the array is left partially cleared.

Optional Feature:
- Macro: CT_IFU_SRAM_RDATA_HOLD_EN.
- Defined:
  - A DATA_WIDTH hold register captures sram_q on every rd_vld cycle; it resets to 0.
  - rd_data = rd_vld ? sram_q : hold register, so rd_data is stable between reads.
  - The hold register is not cleared by an invalidate sweep.
- Undefined: rd_data=sram_q unconditionally; its value is meaningful only while rd_vld=1.

Test Plan:
- Reset release, INV_ON_RESET=1: inv_busy high 512 cycles; sram_a walks 0..511 with cen=0, gwen=0, wen=0, d=0; inv_done pulses once; then read idx 511 -> rd_vld next cycle with rd_data=0.
- Write idx 0x1A5 data 0x3FFFFF mask all 1, then read 0x1A5 next cycle -> rd_gnt, then rd_vld=1 with rd_data=0x3FFFFF.
- Masked write idx 7 data 0x000000 mask 0x0007FF over 0x3FFFFF -> readback 0x3FF800; check sram_wen=0x3FF800 on the write cycle.
- wr_req and rd_req both high for 1 cycle, rd held -> wr_gnt first cycle, rd_gnt second, rd_vld third.
- inv_req pulse while rd_req held high, then a second inv_req at sweep count 100 -> rd_gnt=0 for the full 512-cycle sweep, single inv_done, read granted the cycle after INV exits.
- cpurst_b low at sweep count 300 -> all outputs at reset values immediately; after release the sweep restarts at sram_a=0. With CT_IFU_SRAM_RDATA_HOLD_EN, rd_data=0 until the first read.

Source files
------------

// File: rtl/ct_ifu_spsram_512x22_ctrl.sv
// Access controller for the IFU 512x22 single-port SRAM: write/read arbitration plus an invalidate sweep.
// Optional macro CT_IFU_SRAM_RDATA_HOLD_EN keeps rd_data stable between reads.
module ct_ifu_spsram_512x22_ctrl #(
   parameter int ADDR_WIDTH   = 9,
   parameter int DATA_WIDTH   = 22,
   parameter int INV_ON_RESET = 1
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  inv_req,
   output logic                  inv_busy,
   output logic                  inv_done,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] wr_mask,
   output logic                  wr_gnt,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_idx,
   output logic                  rd_gnt,
   output logic                  rd_vld,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_INV  = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1'b1);
   localparam logic [DATA_WIDTH-1:0] D_ZERO   = {DATA_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] D_ONES   = {DATA_WIDTH{1'b1}};
   localparam logic                  INIT_PEND = (INV_ON_RESET != 0) ? 1'b1 : 1'b0;

   state_t                  state_r;
   logic [ADDR_WIDTH-1:0]   inv_cnt_r;
   logic                    inv_done_r;
   logic                    rd_vld_r;
   logic                    init_pend_r;
   logic                    start_inv_s;
   logic                    last_s;
   logic                    wr_gnt_s;
   logic                    rd_gnt_s;
   logic [ADDR_WIDTH-1:0]   sram_a_s;
   logic                    sram_cen_s;
   logic                    sram_gwen_s;
   logic [DATA_WIDTH-1:0]   sram_wen_s;
   logic [DATA_WIDTH-1:0]   sram_d_s;

   // init_pend_r stands in for an inv_req on the first edge after reset release.
   assign start_inv_s = inv_req | init_pend_r;
   assign last_s      = (state_r == ST_INV) && (inv_cnt_r == CNT_LAST);

   // Grant arbitration: invalidate beats write beats read; nothing is granted in reset or INV.
   always_comb begin
      wr_gnt_s = 1'b0;
      rd_gnt_s = 1'b0;
      if (cpurst_b && (state_r == ST_IDLE) && !start_inv_s) begin
         if (wr_req) begin
            wr_gnt_s = 1'b1;
         end else if (rd_req) begin
            rd_gnt_s = 1'b1;
         end else begin
            wr_gnt_s = 1'b0;
            rd_gnt_s = 1'b0;
         end
      end else begin
         wr_gnt_s = 1'b0;
         rd_gnt_s = 1'b0;
      end
   end

   // SRAM pin mux: sweep, granted write, granted read, or parked.
   always_comb begin
      sram_a_s    = CNT_ZERO;
      sram_cen_s  = 1'b1;
      sram_gwen_s = 1'b1;
      sram_wen_s  = D_ONES;
      sram_d_s    = D_ZERO;
      case (state_r)
         ST_INV: begin
            sram_a_s    = inv_cnt_r;
            sram_cen_s  = 1'b0;
            sram_gwen_s = 1'b0;
            sram_wen_s  = D_ZERO;
            sram_d_s    = D_ZERO;
         end
         ST_IDLE: begin
            if (wr_gnt_s) begin
               sram_a_s    = wr_idx;
               sram_cen_s  = 1'b0;
               sram_gwen_s = 1'b0;
               sram_wen_s  = ~wr_mask;
               sram_d_s    = wr_data;
            end else if (rd_gnt_s) begin
               sram_a_s    = rd_idx;
               sram_cen_s  = 1'b0;
               sram_gwen_s = 1'b1;
               sram_wen_s  = D_ONES;
               sram_d_s    = D_ZERO;
            end else begin
               sram_a_s    = CNT_ZERO;
               sram_cen_s  = 1'b1;
               sram_gwen_s = 1'b1;
               sram_wen_s  = D_ONES;
               sram_d_s    = D_ZERO;
            end
         end
         default: begin
            sram_a_s    = CNT_ZERO;
            sram_cen_s  = 1'b1;
            sram_gwen_s = 1'b1;
            sram_wen_s  = D_ONES;
            sram_d_s    = D_ZERO;
         end
      endcase
   end

   // Sweep FSM, sweep counter, done pulse and read-valid pipeline.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_r     <= ST_IDLE;
         inv_cnt_r   <= CNT_ZERO;
         inv_done_r  <= 1'b0;
         rd_vld_r    <= 1'b0;
         init_pend_r <= INIT_PEND;
      end else begin
         inv_done_r <= 1'b0;
         rd_vld_r   <= rd_gnt_s;
         case (state_r)
            ST_IDLE: begin
               inv_cnt_r <= CNT_ZERO;
               if (start_inv_s) begin
                  state_r     <= ST_INV;
                  init_pend_r <= 1'b0;
               end else begin
                  state_r     <= ST_IDLE;
               end
            end
            ST_INV: begin
               if (last_s) begin
                  state_r    <= ST_IDLE;
                  inv_cnt_r  <= CNT_ZERO;
                  inv_done_r <= 1'b1;
               end else begin
                  state_r    <= ST_INV;
                  inv_cnt_r  <= inv_cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               inv_cnt_r <= CNT_ZERO;
            end
         endcase
      end
   end

`ifdef CT_IFU_SRAM_RDATA_HOLD_EN
   logic [DATA_WIDTH-1:0] hold_r;

   // Last returned read word; deliberately untouched by the sweep.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         hold_r <= D_ZERO;
      end else if (rd_vld_r) begin
         hold_r <= sram_q;
      end else begin
         hold_r <= hold_r;
      end
   end

   assign rd_data = rd_vld_r ? sram_q : hold_r;
`else
   assign rd_data = sram_q;
`endif

   assign inv_busy  = (state_r == ST_INV);
   assign inv_done  = inv_done_r;
   assign rd_vld    = rd_vld_r;
   assign wr_gnt    = wr_gnt_s;
   assign rd_gnt    = rd_gnt_s;
   assign sram_a    = sram_a_s;
   assign sram_cen  = sram_cen_s;
   assign sram_gwen = sram_gwen_s;
   assign sram_wen  = sram_wen_s;
   assign sram_d    = sram_d_s;

endmodule

// File: tb/tb_ct_ifu_spsram_512x22_ctrl.sv
// Directed bench for ct_ifu_spsram_512x22_ctrl with a behavioural SRAM and a read-data scoreboard.
module tb_ct_ifu_spsram_512x22_ctrl;

   logic        clk = 1'b0;
   logic        cpurst_b;
   logic        inv_req, wr_req, rd_req;
   logic [8:0]  wr_idx, rd_idx;
   logic [21:0] wr_data, wr_mask;
   logic        inv_busy, inv_done, wr_gnt, rd_gnt, rd_vld;
   logic [21:0] rd_data;
   logic [8:0]  sram_a;
   logic        sram_cen, sram_gwen;
   logic [21:0] sram_wen, sram_d;
   logic [21:0] sram_q;

   int checks = 0;
   int errors = 0;
   logic [21:0] ref_mem [512];
   logic [21:0] sb [$];
   logic [21:0] mem [512];

   ct_ifu_spsram_512x22_ctrl dut (
      .forever_cpuclk(clk), .cpurst_b(cpurst_b),
      .inv_req(inv_req), .inv_busy(inv_busy), .inv_done(inv_done),
      .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data), .wr_mask(wr_mask), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_idx(rd_idx), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
      .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
      .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
   );

   always #5 clk = ~clk;

   // Behavioural single-port SRAM, one-cycle read latency, bit-masked write.
   always @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         else            sram_q <= mem[sram_a];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop on rd_vld, push the model's word on rd_gnt.
   always @(negedge clk) begin
      #2;
      if (cpurst_b) begin
         if (rd_vld) begin
            if (sb.size() == 0) chk("rd_vld_unexpected", 64'(rd_vld), 64'd0);
            else chk("rd_data", 64'(rd_data), 64'(sb.pop_front()));
         end
         if (rd_gnt) sb.push_back(ref_mem[rd_idx]);
      end
   end

   task automatic drive(input logic w, input logic [8:0] wi, input logic [21:0] wd,
                        input logic [21:0] wm, input logic r, input logic [8:0] ri, input logic iv);
      @(negedge clk);
      wr_req = w; wr_idx = wi; wr_data = wd; wr_mask = wm;
      rd_req = r; rd_idx = ri; inv_req = iv;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 9'h0, 22'h0, 22'h0, 1'b0, 9'h0, 1'b0);
   endtask

   // Granted write: check pins and update the reference image.
   task automatic do_write(input logic [8:0] wi, input logic [21:0] wd, input logic [21:0] wm);
      drive(1'b1, wi, wd, wm, 1'b0, 9'h0, 1'b0);
      chk("wr_pins", {wr_gnt, rd_gnt, sram_cen, sram_gwen, sram_a, sram_d, sram_wen},
          {1'b1, 1'b0, 1'b0, 1'b0, wi, wd, ~wm});
      ref_mem[wi] = (ref_mem[wi] & ~wm) | (wd & wm);
   endtask

   task automatic do_read(input logic [8:0] ri);
      drive(1'b0, 9'h0, 22'h0, 22'h0, 1'b1, ri, 1'b0);
      chk("rd_pins", {wr_gnt, rd_gnt, sram_cen, sram_gwen, sram_a, sram_wen},
          {1'b0, 1'b1, 1'b0, 1'b1, ri, 22'h3FFFFF});
   endtask

   // n sweep cycles; inv_req re-pulsed at cycle inv_at, rd_req held at rdq.
   task automatic sweep_cycles(input int n, input int inv_at, input logic rdq);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 9'h0, 22'h0, 22'h0, rdq, 9'h1A5, (i == inv_at));
         chk($sformatf("sweep_%0d", i),
             {inv_busy, inv_done, wr_gnt, rd_gnt, sram_cen, sram_gwen, sram_wen, sram_d, sram_a},
             {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 22'h0, 9'(i)});
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         mem[i] = 22'h3FFFFF;
         ref_mem[i] = 22'h0;
      end
      inv_req = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
      wr_idx = 9'h3; rd_idx = 9'h3; wr_data = 22'h1; wr_mask = 22'h3FFFFF;
      cpurst_b = 1'b1;
      #1 cpurst_b = 1'b0;
      #3;
      chk("reset_outs", {inv_busy, inv_done, rd_vld, wr_gnt, rd_gnt, sram_cen, sram_gwen, sram_wen},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 22'h3FFFFF});
      repeat (2) @(negedge clk);

      // Release: automatic sweep starts on the next edge.
      idle();
      cpurst_b = 1'b1;
      #1 chk("release_no_gnt", {wr_gnt, rd_gnt, inv_busy, sram_cen}, {1'b0, 1'b0, 1'b0, 1'b1});
      sweep_cycles(512, -1, 1'b0);
      idle();
      chk("sweep1_done", {inv_done, inv_busy, sram_cen}, {1'b1, 1'b0, 1'b1});
      do_read(9'h1FF);
      chk("done_single", 64'(inv_done), 64'd0);
      idle();
      chk("rd511_vld", {rd_vld, rd_data}, {1'b1, 22'h0});
      chk("idle_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
          {1'b1, 1'b1, 22'h3FFFFF, 9'h0, 22'h0});

      // Full write then immediate read.
      do_write(9'h1A5, 22'h3FFFFF, 22'h3FFFFF);
      do_read(9'h1A5);
      idle();
      chk("rd1a5", {rd_vld, rd_data}, {1'b1, 22'h3FFFFF});

      // Masked write over all-ones.
      do_write(9'h007, 22'h3FFFFF, 22'h3FFFFF);
      do_write(9'h007, 22'h000000, 22'h0007FF);
      chk("mask_wen", 64'(sram_wen), 64'h3FF800);
      do_read(9'h007);
      idle();
      chk("rd7", {rd_vld, rd_data}, {1'b1, 22'h3FF800});

      // Zero-mask write is still granted and changes nothing.
      do_write(9'h007, 22'h155555, 22'h000000);

      // Write and read together: write first, read next, data after.
      drive(1'b1, 9'h020, 22'h12345, 22'h3FFFFF, 1'b1, 9'h020, 1'b0);
      chk("both_wr_first", {wr_gnt, rd_gnt, sram_gwen, sram_a}, {1'b1, 1'b0, 1'b0, 9'h020});
      ref_mem[9'h020] = 22'h12345;
      do_read(9'h020);
      chk("both_vld_late", 64'(rd_vld), 64'd0);
      idle();
      chk("both_rd_vld", {rd_vld, rd_data}, {1'b1, 22'h12345});

      // Back-to-back reads at full throughput.
      do_read(9'h1A5);
      do_read(9'h007);
      chk("b2b_vld", {rd_vld, rd_data}, {1'b1, 22'h3FFFFF});
      do_read(9'h020);
      chk("b2b_vld2", {rd_vld, rd_data}, {1'b1, 22'h3FF800});
      idle();
      chk("b2b_vld3", {rd_vld, rd_data}, {1'b1, 22'h12345});

      // inv_req with a held read; second inv_req mid-sweep is ignored.
      drive(1'b1, 9'h020, 22'h0, 22'h3FFFFF, 1'b1, 9'h1A5, 1'b1);
      chk("inv_wins", {wr_gnt, rd_gnt, inv_busy, sram_cen}, {1'b0, 1'b0, 1'b0, 1'b1});
      for (int i = 0; i < 512; i++) ref_mem[i] = 22'h0;
      sweep_cycles(512, 100, 1'b1);
      drive(1'b0, 9'h0, 22'h0, 22'h0, 1'b1, 9'h1A5, 1'b0);
      chk("sweep2_exit", {inv_done, inv_busy, rd_gnt, sram_a}, {1'b1, 1'b0, 1'b1, 9'h1A5});
      idle();
      chk("sweep2_rd", {inv_done, rd_vld, rd_data}, {1'b0, 1'b1, 22'h0});

      // Reset at sweep count 300, then the sweep restarts from index 0.
      drive(1'b0, 9'h0, 22'h0, 22'h0, 1'b0, 9'h0, 1'b1);
      sweep_cycles(300, -1, 1'b0);
      @(negedge clk);
      cpurst_b = 1'b0; wr_req = 1'b1; rd_req = 1'b1; inv_req = 1'b0;
      #1;
      chk("midreset", {inv_busy, inv_done, rd_vld, wr_gnt, rd_gnt, sram_cen, sram_gwen, sram_wen},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 22'h3FFFFF});
`ifdef CT_IFU_SRAM_RDATA_HOLD_EN
      chk("hold_reset", 64'(rd_data), 64'd0);
`endif
      idle();
      cpurst_b = 1'b1;
      sweep_cycles(512, -1, 1'b0);
`ifdef CT_IFU_SRAM_RDATA_HOLD_EN
      chk("hold_until_read", 64'(rd_data), 64'd0);
`endif
      idle();
      chk("sweep3_done", {inv_done, inv_busy}, {1'b1, 1'b0});
      do_read(9'h12C);
      idle();
      chk("sweep3_rd", {rd_vld, rd_data}, {1'b1, 22'h0});
      idle();
      chk("rd_vld_drop", 64'(rd_vld), 64'd0);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
